// File: rtl/ex_div_pkg.sv
// Shared constants and state encodings for the iterative execute-stage divider.
package ex_div_pkg;

    localparam int RegBusW       = 32;
    localparam int DoubleRegBusW = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    function automatic logic [RegBusW-1:0] neg32(input logic [RegBusW-1:0] v);
        return ~v + {{(RegBusW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ex_div.sv
// Restoring divider for DIV/DIVU: one quotient bit per clock, result {remainder, quotient}.
module ex_div
    import ex_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state_reg,    state_next;
    logic [5:0]  cnt_reg,      cnt_next;
    logic [64:0] work_reg,     work_next;
    logic [31:0] divisor_reg,  divisor_next;
    logic        neg_quot_reg, neg_quot_next;
    logic        neg_rem_reg,  neg_rem_next;
    logic [63:0] result_reg,   result_next;
    logic        ready_reg,    ready_next;

    logic [64:0] shifted;
    logic [32:0] diff;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= DivFree;
            cnt_reg      <= 6'd0;
            work_reg     <= 65'd0;
            divisor_reg  <= 32'd0;
            neg_quot_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            result_reg   <= 64'd0;
            ready_reg    <= DivResultNotReady;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            work_reg     <= work_next;
            divisor_reg  <= divisor_next;
            neg_quot_reg <= neg_quot_next;
            neg_rem_reg  <= neg_rem_next;
            result_reg   <= result_next;
            ready_reg    <= ready_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        work_next     = work_reg;
        divisor_next  = divisor_reg;
        neg_quot_next = neg_quot_reg;
        neg_rem_next  = neg_rem_reg;
        result_next   = result_reg;
        ready_next    = ready_reg;

        // work_reg[64:32] is the partial remainder, [31:0] shifts dividend out and quotient in
        shifted = {work_reg[63:0], 1'b0};
        diff    = shifted[64:32] - {1'b0, divisor_reg};

        dividend_mag = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
        divisor_mag  = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
        quot_fix     = neg_quot_reg ? neg32(work_reg[31:0])  : work_reg[31:0];
        rem_fix      = neg_rem_reg  ? neg32(work_reg[63:32]) : work_reg[63:32];

        unique case (state_reg)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_next = DivByZero;
                    end else begin
                        state_next    = DivOn;
                        cnt_next      = 6'd0;
                        work_next     = {33'd0, dividend_mag};
                        divisor_next  = divisor_mag;
                        neg_quot_next = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_next  = signed_div_i && opdata1_i[31];
                    end
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    result_next = 64'd0;
                    ready_next  = DivResultNotReady;
                end else begin
                    state_next  = DivEnd;
                    result_next = 64'd0;
                    ready_next  = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    result_next = 64'd0;
                    ready_next  = DivResultNotReady;
                end else if (cnt_reg != 6'd32) begin
                    // A set top bit means the trial subtraction went negative: restore
                    if (diff[32]) begin
                        work_next = shifted;
                    end else begin
                        work_next = {diff, shifted[31:1], 1'b1};
                    end
                    cnt_next = cnt_reg + 6'd1;
                end else begin
                    state_next  = DivEnd;
                    result_next = {rem_fix, quot_fix};
                    ready_next  = DivResultReady;
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    state_next  = DivFree;
                    result_next = 64'd0;
                    ready_next  = DivResultNotReady;
                end
            end
            default: begin
                state_next = DivFree;
            end
        endcase
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit divider used by the execute stage for DIV/DIVU. The execute stage consumes the operands registered by the ID/EX pipeline register, raises `start_i`, and holds its stall request until `ready_o` returns the 64-bit {remainder, quotient} result for the HI/LO write path. One quotient bit is produced per cycle. A pipeline flush aborts the operation through `annul_i`.

## Interface
- No parameters. Operand width is fixed at 32 bits (`RegBus`). Result width is fixed at 64 bits (`DoubleRegBus`).
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled when the start is accepted.
- `opdata1_i`  in  32  dividend. Sampled when the start is accepted.
- `opdata2_i`  in  32  divisor. Sampled when the start is accepted.
- `start_i`  in  1  request. EX holds it high until it sees `ready_o`.
- `annul_i`  in  1  abort the operation in flight (flush).
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}. Registered.
- `ready_o`  out  1  result valid. Registered.

## Operation
- States (`DivFree`, `DivByZero`, `DivOn`, `DivEnd`) use 2-bit encodings from `defines.v`. A 6-bit iteration counter `cnt` runs from 0 to 32.
- **`DivFree`**
  - Outputs: `ready_o`=0, `result_o`=0.
  - `start_i`=1 with `annul_i`=0 and divisor==0 → go to `DivByZero`.
  - `start_i`=1 with `annul_i`=0 and divisor≠0 → go to `DivOn`, latch the operands and clear `cnt`.
  - `start_i`=1 with `annul_i`=1 → ignored; stay in `DivFree`.
- **Signed operand handling** (`signed_div_i`=1): negative operands are replaced by their two's-complement magnitude when the operands are latched. The original signs are stored.
- **`DivOn`**: one restoring step per edge while `cnt`<32.
  - Shift the 33-bit partial remainder left by one bit and bring in the next dividend bit, MSB first.
  - Trial-subtract the divisor magnitude.
  - If the difference is non-negative, keep it and the quotient bit is 1; otherwise the quotient bit is 0.
  - Increment `cnt`.
- **Leaving `DivOn`** (`cnt`==32 edge): go to `DivEnd`.
  - Signed only: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
  - Load `result_o` and set `ready_o`=1.
- **`DivByZero`**: the next edge goes to `DivEnd` with `result_o`=0 and `ready_o`=1.
- **`DivEnd`**
  - Holds `result_o` and `ready_o`=1 while `start_i`=1.
  - `start_i`=0 → go to `DivFree`; `ready_o` and `result_o` clear on that edge.
- **Annul**: `annul_i`=1 in `DivOn`, `DivByZero` or `DivEnd` → go to `DivFree` on the next edge with outputs cleared. No result is produced.
- **Arithmetic rules**
  - Quotient and remainder wrap modulo 2^32.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Divide by zero returns 0 in both halves (the architecture leaves the value undefined; this block fixes it to 0).

## Timing
- **Reset**: reset low forces `DivFree`, `cnt`=0, `result_o`=0, `ready_o`=0 immediately, with no clock needed. This holds mid-operation; no partial result survives.
- **Normal latency**: edge 1 accepts the start, edges 2–33 are the 32 steps, edge 34 enters `DivEnd`. `ready_o` is high after the 34th edge following the first edge with `start_i` high.
- **Divide-by-zero latency**: `ready_o` is high after the 2nd edge.
- **Back-to-back operations**: a new start is accepted only from `DivFree`. The minimum spacing is 1 idle cycle after `start_i` falls.
- **Operand stability**: operand changes after acceptance have no effect.

## Structure
- Constants belong in `defines.v`: state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd`, plus `DivResultReady`/`DivResultNotReady` and `DivStart`/`DivStop`.
- `DoubleRegBus` is also defined in `defines.v`.
- Single module, no sub-module. The step datapath is one 33-bit subtractor and a 65-bit shift register {remainder, dividend/quotient} inside `ex_div`.
- The EX stage instantiates `ex_div`. It ORs `!ready_o && start_i` into its stall request.

## Test plan
- **DIVU 100 / 7**, start held → `ready_o` after edge 34; `result_o` = 0x00000002_0000000E; outputs clear the edge after `start_i` falls.
- **DIV -7 / 2** (0xFFFFFFF9, 0x00000002) → `result_o` = 0xFFFFFFFF_FFFFFFFD.
- **DIV 0x80000000 / 0xFFFFFFFF** → 0x00000000_80000000. **DIVU 0xFFFFFFFF / 1** → 0x00000000_FFFFFFFF.
- **Divisor 0**, signed and unsigned → `ready_o` after edge 2; `result_o` = 0.
- **Annul** pulse at the 10th edge of `DivOn` → next edge is `DivFree`. `ready_o` never rises. A following DIVU 9/3 returns 0x00000000_00000003 after 34 edges.
- **Reset low mid-`DivOn`** (asynchronous, between edges) → outputs 0 immediately. After reset is released, an operation completes normally.
